// File: rtl/filter_stream_buffer.sv
// filter_stream_buffer: plays a preloaded stimulus frame into a filter under test and captures its response
module filter_stream_buffer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_loop,
    input  logic [ADDR_W-1:0] len,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_we,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       frame_cnt,
    output logic [ADDR_W:0]   cap_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;
    state_t state;
    logic [DATA_W-1:0] play_ram [2**ADDR_W];
    logic [DATA_W-1:0] cap_ram [2**ADDR_W];
    logic [ADDR_W:0] len_r;
    logic mode_r;
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [TW-1:0] drain_cnt;
    logic last_rd, cap_full, cap_wrap, cap_en;
    assign busy = state != IDLE;
    assign last_rd = {1'b0, rd_ptr} == len_r - ONE;
    assign cap_full = cap_cnt == len_r;
    assign cap_wrap = cap_cnt == len_r - ONE;
    // one-shot capture saturates at the frame length; loop capture wraps instead
    assign cap_en = busy && in_valid && !(cap_full && !mode_r) && !rst;
    always_ff @(posedge clk) begin
        if (host_we && !busy) play_ram[host_addr] <= host_wdata;
        if (cap_en) cap_ram[wr_ptr] <= in_sample;
        host_rdata <= cap_ram[host_addr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            timeout    <= 1'b0;
            frame_cnt  <= '0;
            cap_cnt    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            len_r      <= '0;
            mode_r     <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            done <= 1'b0;
            // a read issued in the stop cycle is dropped
            out_valid <= state == PLAY && !stop;
            if (state == PLAY && !stop) out_sample <= play_ram[rd_ptr];
            if (cap_en) begin
                wr_ptr  <= mode_r && cap_wrap ? '0 : wr_ptr + ADDR_W'(1);
                cap_cnt <= mode_r && cap_wrap ? '0 : cap_cnt + ONE;
            end
            case (state)
                IDLE: if (start) begin
                    state     <= PLAY;
                    len_r     <= {len == '0, len};
                    mode_r    <= mode_loop;
                    rd_ptr    <= '0;
                    wr_ptr    <= '0;
                    cap_cnt   <= '0;
                    frame_cnt <= '0;
                    timeout   <= 1'b0;
                end
                PLAY: if (stop) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else if (last_rd && !mode_r) begin
                    state     <= DRAIN;
                    drain_cnt <= '0;
                end else begin
                    rd_ptr <= last_rd ? '0 : rd_ptr + ADDR_W'(1);
                    if (last_rd) frame_cnt <= frame_cnt + 16'd1;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + TW'(1);
                    if (stop || cap_full || drain_cnt == TW'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        timeout <= !stop && !cap_full;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filter_stream_buffer.sv
// tb_filter_stream_buffer: directed run table plus reset and readback sequences
module tb_filter_stream_buffer;
    localparam int DW = 32, AW = 12, TO = 1024, DEPTH = 4096;
    logic clk = 1'b0;
    logic rst, start, stop, mode_loop, in_valid, host_we, out_valid, busy, done, timeout;
    logic [AW-1:0] len, host_addr;
    logic [DW-1:0] out_sample, in_sample, host_wdata, host_rdata;
    logic [15:0] frame_cnt;
    logic [AW:0] cap_cnt;
    logic [DW-1:0] pb [DEPTH];
    int checks = 0, errors = 0;
    typedef struct {
        int len; bit loop; bit lb; int stop_after; bit stop0; int poke;
        int outs; int done_at; int frames; int cap; bit to;
    } run_t;
    run_t runs [9];
    always #5 clk = ~clk;
    filter_stream_buffer #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_loop(mode_loop), .len(len),
        .out_sample(out_sample), .out_valid(out_valid), .in_sample(in_sample), .in_valid(in_valid),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_rdata(host_rdata),
        .busy(busy), .done(done), .timeout(timeout), .frame_cnt(frame_cnt), .cap_cnt(cap_cnt)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick(input bit lb);
        @(negedge clk);
        in_valid = lb & out_valid;
        in_sample = out_sample;
    endtask
    task automatic run(input run_t r);
        int outs, first, done_at, le;
        outs = 0; first = -1; done_at = -1;
        le = r.len == 0 ? DEPTH : r.len;
        len = AW'(r.len); mode_loop = r.loop; start = 1'b1; stop = r.stop0;
        for (int n = 1; n <= le + TO + 50 && done_at < 0; n++) begin
            tick(r.lb);
            start = 1'b0; stop = 1'b0; host_we = 1'b0;
            if (n == 1) begin
                chk("busy_after_start", 32'(busy), 1);
                chk("timeout_cleared", 32'(timeout), 0);
            end
            if (out_valid) begin
                chk("sample", out_sample, pb[outs % le]);
                if (first < 0) first = n;
                outs++;
                if (outs == r.stop_after) stop = 1'b1;
            end
            if (n == r.poke) begin
                start = 1'b1; host_we = 1'b1; host_addr = 5; host_wdata = 32'hdead_beef;
            end
            if (done) done_at = n;
        end
        chk("done_cycle", done_at, r.done_at);
        chk("out_count", outs, r.outs);
        chk("first_valid", first, 2);
        chk("busy_at_done", 32'(busy), 0);
        chk("valid_at_done", 32'(out_valid), 0);
        chk("frame_cnt", 32'(frame_cnt), r.frames);
        chk("cap_cnt", 32'(cap_cnt), r.cap);
        chk("timeout", 32'(timeout), 32'(r.to));
        tick(1'b0);
        chk("done_pulse_end", 32'(done), 0);
    endtask
    initial begin
        runs[0] = '{8, 0, 1, 0, 0, 0, 8, 11, 0, 8, 0};
        runs[1] = '{4, 0, 0, 0, 0, 0, 4, TO + 5, 0, 0, 1};
        runs[2] = '{3, 1, 1, 10, 0, 0, 10, 12, 3, 1, 0};
        runs[3] = '{0, 0, 1, 0, 0, 0, DEPTH, DEPTH + 3, 0, DEPTH, 0};
        runs[4] = '{1, 0, 1, 0, 1, 0, 1, 4, 0, 1, 0};
        runs[5] = '{10, 0, 1, 4, 0, 0, 4, 6, 0, 4, 0};
        runs[6] = '{5, 1, 0, 7, 0, 0, 7, 9, 1, 0, 0};
        runs[7] = '{8, 0, 1, 0, 0, 3, 8, 11, 0, 8, 0};
        runs[8] = '{8, 0, 1, 0, 0, 0, 8, 11, 0, 8, 0};
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode_loop = 1'b0; len = '0;
        in_valid = 1'b0; in_sample = '0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) tick(1'b0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_cap_cnt", 32'(cap_cnt), 0);
        chk("rst_out_sample", out_sample, 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            host_addr = AW'(i); host_wdata = 32'h100 + i; host_we = 1'b1; pb[i] = 32'h100 + i;
            tick(1'b0);
        end
        host_we = 1'b0;
        len = 8; mode_loop = 1'b0; start = 1'b1;
        tick(1'b1);
        start = 1'b0;
        repeat (3) tick(1'b1);
        chk("cap_before_rst", 32'(cap_cnt), 2);
        rst = 1'b1;
        tick(1'b1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_cap_cnt", 32'(cap_cnt), 0);
        chk("midrst_out_sample", out_sample, 0);
        rst = 1'b0;
        tick(1'b0);
        chk("midrst_no_done", 32'(done), 0);
        for (int i = 0; i < 9; i++) run(runs[i]);
        for (int i = 0; i < 8; i++) begin
            host_addr = AW'(i);
            tick(1'b0);
            chk("capture_readback", host_rdata, 32'h100 + i);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
